// File: rtl/servant_ram_sched.sv
// servant_ram_sched: shares the single-port servant RAM between three
// Wishbone masters (M0 CPU ibus, M1 CPU dbus, M2 debug system bus).
// Round-robin arbitration with an optional fixed priority for M2, and the
// grant stays locked until the RAM acks, the owner aborts, or it times out.
// Build option: define SERVANT_RAM_SCHED_TIMEOUT_EN to add the BUSY
// watchdog that error-acks a stalled transfer with ERR_DATA and pulses o_err.
module servant_ram_sched #(
    parameter int          DBG_PRIO = 1,
    parameter int          TIMEOUT  = 255,
    parameter int          TO_W     = 8,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    // M0: CPU instruction bus (read only)
    input  logic [31:0] i_m0_adr,
    input  logic        i_m0_cyc,
    output logic [31:0] o_m0_rdt,
    output logic        o_m0_ack,
    // M1: CPU data bus
    input  logic [31:0] i_m1_adr,
    input  logic [31:0] i_m1_dat,
    input  logic [3:0]  i_m1_sel,
    input  logic        i_m1_we,
    input  logic        i_m1_cyc,
    output logic [31:0] o_m1_rdt,
    output logic        o_m1_ack,
    // M2: debug module system bus
    input  logic [31:0] i_m2_adr,
    input  logic [31:0] i_m2_dat,
    input  logic [3:0]  i_m2_sel,
    input  logic        i_m2_we,
    input  logic        i_m2_cyc,
    output logic [31:0] o_m2_rdt,
    output logic        o_m2_ack,
    // RAM side
    output logic [31:0] o_s_adr,
    output logic [31:0] o_s_dat,
    output logic [3:0]  o_s_sel,
    output logic        o_s_we,
    output logic        o_s_cyc,
    input  logic [31:0] i_s_rdt,
    input  logic        i_s_ack,
    // status
    output logic [1:0]  o_grant,
    output logic        o_err
);

    // Elaboration-time sanity check of the watchdog limit.
    if (TIMEOUT < 1 || TIMEOUT >= (1 << TO_W)) begin : g_bad_timeout
        $error("servant_ram_sched: TIMEOUT must be in 1..2**TO_W-1");
    end

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    localparam logic [1:0] GRANT_NONE = 2'd3;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] grant_nxt;
    logic [1:0] last;
    logic [1:0] last_nxt;

    logic [2:0]  req;
    logic [1:0]  winner;
    logic        busy;
    logic        own_cyc;
    logic        timeout_hit;
    logic        owner_ack;
    logic [31:0] owner_rdt;

    assign req  = {i_m2_cyc, i_m1_cyc, i_m0_cyc};
    assign busy = (state == BUSY);

    // Next master after idx in the rotation M0 -> M1 -> M2 -> M0.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Winner among the current requests: M2 first when it has priority,
    // otherwise search last+1, last+2, then last itself.
    function automatic logic [1:0] arbitrate(input logic [2:0] r,
                                             input logic [1:0] prev,
                                             input logic       m2_first);
        logic [1:0] c1;
        logic [1:0] c2;
        c1 = rr_next(prev);
        c2 = rr_next(c1);
        if (m2_first && r[2])
            return 2'd2;
        else if (r[c1])
            return c1;
        else if (r[c2])
            return c2;
        else
            return prev;
    endfunction

    assign winner = arbitrate(req, last, (DBG_PRIO != 0));

    // Request line of whichever master currently owns the RAM.
    always_comb begin
        own_cyc = 1'b0;
        case (o_grant)
            2'd0:    own_cyc = i_m0_cyc;
            2'd1:    own_cyc = i_m1_cyc;
            2'd2:    own_cyc = i_m2_cyc;
            default: own_cyc = 1'b0;
        endcase
    end

`ifdef SERVANT_RAM_SCHED_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;

    // Watchdog: zero while idle (so it is clear on BUSY entry), then counts
    // every BUSY cycle in which the RAM does not ack.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            to_cnt <= '0;
        else if (state == IDLE)
            to_cnt <= '0;
        else if (!i_s_ack)
            to_cnt <= to_cnt + 1'b1;
    end

    // A real ack in the limit cycle wins over the error-ack.
    assign timeout_hit = busy && own_cyc && !i_s_ack &&
                         (to_cnt == TO_W'(TIMEOUT));
`else
    assign timeout_hit = 1'b0;
`endif

    // Completion of the owner's cycle: real ack or watchdog error-ack.
    // Once the owner has dropped cyc a late RAM ack is not forwarded.
    assign owner_ack = busy && own_cyc && (i_s_ack || timeout_hit);
    assign owner_rdt = timeout_hit ? ERR_DATA : i_s_rdt;
    assign o_err     = timeout_hit;

    // Return path: only the owner sees ack and read data, others read zero.
    always_comb begin
        o_m0_ack = 1'b0;
        o_m1_ack = 1'b0;
        o_m2_ack = 1'b0;
        o_m0_rdt = '0;
        o_m1_rdt = '0;
        o_m2_rdt = '0;
        if (busy) begin
            case (o_grant)
                2'd0: begin
                    o_m0_ack = owner_ack;
                    o_m0_rdt = owner_rdt;
                end
                2'd1: begin
                    o_m1_ack = owner_ack;
                    o_m1_rdt = owner_rdt;
                end
                2'd2: begin
                    o_m2_ack = owner_ack;
                    o_m2_rdt = owner_rdt;
                end
                default: ;
            endcase
        end
    end

    // Forward path: owner's request straight to the RAM; M0 is a read-only
    // full-word master. The RAM cycle ends in the same cycle the owner
    // drops cyc or the watchdog fires.
    always_comb begin
        o_s_adr = '0;
        o_s_dat = '0;
        o_s_sel = '0;
        o_s_we  = 1'b0;
        o_s_cyc = 1'b0;
        if (busy) begin
            case (o_grant)
                2'd0: begin
                    o_s_adr = i_m0_adr;
                    o_s_dat = '0;
                    o_s_sel = 4'hF;
                    o_s_we  = 1'b0;
                end
                2'd1: begin
                    o_s_adr = i_m1_adr;
                    o_s_dat = i_m1_dat;
                    o_s_sel = i_m1_sel;
                    o_s_we  = i_m1_we;
                end
                2'd2: begin
                    o_s_adr = i_m2_adr;
                    o_s_dat = i_m2_dat;
                    o_s_sel = i_m2_sel;
                    o_s_we  = i_m2_we;
                end
                default: ;
            endcase
            o_s_cyc = own_cyc && !timeout_hit;
        end
    end

    // Next state: arbitrate only in IDLE; BUSY holds the grant until the
    // owner completes or aborts, then always spends one cycle in IDLE.
    always_comb begin
        state_nxt = state;
        grant_nxt = o_grant;
        last_nxt  = last;
        case (state)
            IDLE: begin
                grant_nxt = GRANT_NONE;
                if (|req) begin
                    state_nxt = BUSY;
                    grant_nxt = winner;
                    last_nxt  = winner;
                end
            end
            BUSY: begin
                if (!own_cyc || owner_ack) begin
                    state_nxt = IDLE;
                    grant_nxt = GRANT_NONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = GRANT_NONE;
            end
        endcase
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            o_grant <= GRANT_NONE;
            last    <= 2'd0;
        end else begin
            state   <= state_nxt;
            o_grant <= grant_nxt;
            last    <= last_nxt;
        end
    end

endmodule

// File: tb/tb_servant_ram_sched.sv
// tb_servant_ram_sched: directed bench for servant_ram_sched.
// Instance "a" uses DBG_PRIO=1, instance "b" uses DBG_PRIO=0; both have
// TIMEOUT=4. Master address/data are shared, cyc and RAM ack are separate.
module tb_servant_ram_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_adr, m1_adr, m1_dat, m2_adr, m2_dat, s_rdt;
    logic [3:0]  m1_sel, m2_sel;
    logic        m1_we, m2_we;
    logic        m0_cyc, m1_cyc, m2_cyc, s_ack;
    logic        m0_cyc_b, m1_cyc_b, m2_cyc_b, s_ack_b;

    logic [31:0] a_m0_rdt, a_m1_rdt, a_m2_rdt, a_s_adr, a_s_dat;
    logic        a_m0_ack, a_m1_ack, a_m2_ack, a_s_we, a_s_cyc, a_err;
    logic [3:0]  a_s_sel;
    logic [1:0]  a_grant;

    logic [31:0] b_m0_rdt, b_m1_rdt, b_m2_rdt, b_s_adr, b_s_dat;
    logic        b_m0_ack, b_m1_ack, b_m2_ack, b_s_we, b_s_cyc, b_err;
    logic [3:0]  b_s_sel;
    logic [1:0]  b_grant;

    int checks   = 0;
    int failures = 0;

    servant_ram_sched #(.DBG_PRIO(1), .TIMEOUT(4), .TO_W(8), .ERR_DATA(32'hDEADBEEF)) dut_a (
        .i_clk(clk), .i_rst(rst),
        .i_m0_adr(m0_adr), .i_m0_cyc(m0_cyc), .o_m0_rdt(a_m0_rdt), .o_m0_ack(a_m0_ack),
        .i_m1_adr(m1_adr), .i_m1_dat(m1_dat), .i_m1_sel(m1_sel), .i_m1_we(m1_we),
        .i_m1_cyc(m1_cyc), .o_m1_rdt(a_m1_rdt), .o_m1_ack(a_m1_ack),
        .i_m2_adr(m2_adr), .i_m2_dat(m2_dat), .i_m2_sel(m2_sel), .i_m2_we(m2_we),
        .i_m2_cyc(m2_cyc), .o_m2_rdt(a_m2_rdt), .o_m2_ack(a_m2_ack),
        .o_s_adr(a_s_adr), .o_s_dat(a_s_dat), .o_s_sel(a_s_sel), .o_s_we(a_s_we),
        .o_s_cyc(a_s_cyc), .i_s_rdt(s_rdt), .i_s_ack(s_ack),
        .o_grant(a_grant), .o_err(a_err)
    );

    servant_ram_sched #(.DBG_PRIO(0), .TIMEOUT(4), .TO_W(8), .ERR_DATA(32'hDEADBEEF)) dut_b (
        .i_clk(clk), .i_rst(rst),
        .i_m0_adr(m0_adr), .i_m0_cyc(m0_cyc_b), .o_m0_rdt(b_m0_rdt), .o_m0_ack(b_m0_ack),
        .i_m1_adr(m1_adr), .i_m1_dat(m1_dat), .i_m1_sel(m1_sel), .i_m1_we(m1_we),
        .i_m1_cyc(m1_cyc_b), .o_m1_rdt(b_m1_rdt), .o_m1_ack(b_m1_ack),
        .i_m2_adr(m2_adr), .i_m2_dat(m2_dat), .i_m2_sel(m2_sel), .i_m2_we(m2_we),
        .i_m2_cyc(m2_cyc_b), .o_m2_rdt(b_m2_rdt), .o_m2_ack(b_m2_ack),
        .o_s_adr(b_s_adr), .o_s_dat(b_s_dat), .o_s_sel(b_s_sel), .o_s_we(b_s_we),
        .o_s_cyc(b_s_cyc), .i_s_rdt(s_rdt), .i_s_ack(s_ack_b),
        .o_grant(b_grant), .o_err(b_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 2 ns later.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    logic [1:0] exp_b2 [4] = '{2'd1, 2'd0, 2'd1, 2'd0};
    logic [1:0] exp_b3 [6] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1;
        m0_adr = '0; m1_adr = '0; m1_dat = '0; m2_adr = '0; m2_dat = '0; s_rdt = '0;
        m1_sel = '0; m2_sel = '0; m1_we = 1'b0; m2_we = 1'b0;
        m0_cyc = 1'b0; m1_cyc = 1'b0; m2_cyc = 1'b0; s_ack = 1'b0;
        m0_cyc_b = 1'b0; m1_cyc_b = 1'b0; m2_cyc_b = 1'b0; s_ack_b = 1'b0;
        step(); step();

        // reset state
        check("rst_grant_a", 32'(a_grant), 32'd3);
        check("rst_grant_b", 32'(b_grant), 32'd3);
        check("rst_scyc", 32'(a_s_cyc), 32'd0);
        check("rst_acks", 32'({a_m0_ack, a_m1_ack, a_m2_ack, a_err, a_s_we}), 32'd0);
        rst = 1'b0;
        step();

        // M0 read of 0x100, RAM acks two cycles after o_s_cyc rises
        m0_adr = 32'h100; m0_cyc = 1'b1;
        #1;
        check("t1_scyc_t", 32'(a_s_cyc), 32'd0);
        check("t1_grant_t", 32'(a_grant), 32'd3);
        step();
        check("t1_scyc_t1", 32'(a_s_cyc), 32'd1);
        check("t1_grant", 32'(a_grant), 32'd0);
        check("t1_we", 32'(a_s_we), 32'd0);
        check("t1_sel", 32'(a_s_sel), 32'hF);
        check("t1_adr", a_s_adr, 32'h100);
        check("t1_dat", a_s_dat, 32'd0);
        check("t1_noack", 32'(a_m0_ack), 32'd0);
        step();
        check("t1_noack2", 32'(a_m0_ack), 32'd0);
        step();
        s_ack = 1'b1; s_rdt = 32'h12345678;
        #1;
        check("t1_ack", 32'(a_m0_ack), 32'd1);
        check("t1_rdt", a_m0_rdt, 32'h12345678);
        check("t1_m1_ack", 32'(a_m1_ack), 32'd0);
        check("t1_m1_rdt", a_m1_rdt, 32'd0);
        step();
        s_ack = 1'b0; m0_cyc = 1'b0;
        #1;
        check("t1_grant_end", 32'(a_grant), 32'd3);
        check("t1_ack_end", 32'(a_m0_ack), 32'd0);

        // M1 write; round robin after M0 picks M1
        m1_adr = 32'h20; m1_dat = 32'hA5A5A5A5; m1_sel = 4'h3; m1_we = 1'b1; m1_cyc = 1'b1;
        step();
        check("t4_grant", 32'(a_grant), 32'd1);
        check("t4_we", 32'(a_s_we), 32'd1);
        check("t4_sel", 32'(a_s_sel), 32'h3);
        check("t4_dat", a_s_dat, 32'hA5A5A5A5);
        check("t4_adr", a_s_adr, 32'h20);
        check("t4_m0ack_busy", 32'(a_m0_ack), 32'd0);
        s_ack = 1'b1; s_rdt = 32'h0;
        #1;
        check("t4_ack", 32'(a_m1_ack), 32'd1);
        check("t4_m0ack", 32'(a_m0_ack), 32'd0);
        step();
        s_ack = 1'b0; m1_cyc = 1'b0; m1_we = 1'b0;

        // M1 aborts while BUSY; late RAM ack ignored; M0 then served
        m1_cyc = 1'b1;
        step();
        check("t5_grant", 32'(a_grant), 32'd1);
        check("t5_scyc", 32'(a_s_cyc), 32'd1);
        m1_cyc = 1'b0;
        #1;
        check("t5_scyc_drop", 32'(a_s_cyc), 32'd0);
        check("t5_noack", 32'(a_m1_ack), 32'd0);
        step();
        s_ack = 1'b1;
        #1;
        check("t5_late_ack", 32'(a_m1_ack), 32'd0);
        check("t5_idle", 32'(a_grant), 32'd3);
        step();
        s_ack = 1'b0; m0_adr = 32'h104; m0_cyc = 1'b1;
        step();
        check("t5_m0_grant", 32'(a_grant), 32'd0);
        check("t5_m0_adr", a_s_adr, 32'h104);
        s_ack = 1'b1; s_rdt = 32'hCAFEF00D;
        #1;
        check("t5_m0_ack", 32'(a_m0_ack), 32'd1);
        check("t5_m0_rdt", a_m0_rdt, 32'hCAFEF00D);
        step();
        s_ack = 1'b0; m0_cyc = 1'b0;

        // DBG_PRIO=1: M2 wins while all three request
        m0_cyc = 1'b1; m1_cyc = 1'b1; m2_cyc = 1'b1; m2_adr = 32'h300;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("t3a_grant%0d", i), 32'(a_grant), 32'd2);
            s_ack = 1'b1; s_rdt = 32'h55AA0000 + 32'(i);
            #1;
            check($sformatf("t3a_ack%0d", i), 32'({a_m0_ack, a_m1_ack, a_m2_ack}), 32'b001);
            check($sformatf("t3a_rdt%0d", i), a_m2_rdt, 32'h55AA0000 + 32'(i));
            step();
            s_ack = 1'b0;
        end
        m0_cyc = 1'b0; m1_cyc = 1'b0; m2_cyc = 1'b0;

        // DBG_PRIO=0: M0+M1 alternate starting with M1
        m0_cyc_b = 1'b1; m1_cyc_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("t2_grant%0d", i), 32'(b_grant), 32'(exp_b2[i]));
            check($sformatf("t2_scyc%0d", i), 32'(b_s_cyc), 32'd1);
            s_ack_b = 1'b1;
            step();
            s_ack_b = 1'b0;
        end
        // DBG_PRIO=0 with all three: M1, M2, M0 repeating
        m2_cyc_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("t3b_grant%0d", i), 32'(b_grant), 32'(exp_b3[i]));
            s_ack_b = 1'b1;
            #1;
            check($sformatf("t3b_ack%0d", i), 32'({b_m2_ack, b_m1_ack, b_m0_ack}),
                  32'(3'b001 << exp_b3[i]));
            step();
            s_ack_b = 1'b0;
        end
        m0_cyc_b = 1'b0; m1_cyc_b = 1'b0; m2_cyc_b = 1'b0;
        step();

        // M2 read that the RAM never acks
        m2_adr = 32'h400; m2_we = 1'b0; m2_cyc = 1'b1;
        step();
        check("t6_grant", 32'(a_grant), 32'd2);
`ifdef SERVANT_RAM_SCHED_TIMEOUT_EN
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t6_wait_ack%0d", k), 32'(a_m2_ack), 32'd0);
            check($sformatf("t6_wait_err%0d", k), 32'(a_err), 32'd0);
            step();
        end
        check("t6_to_ack", 32'(a_m2_ack), 32'd1);
        check("t6_to_rdt", a_m2_rdt, 32'hDEADBEEF);
        check("t6_to_err", 32'(a_err), 32'd1);
        check("t6_to_scyc", 32'(a_s_cyc), 32'd0);
        m2_cyc = 1'b0;
        step();
        check("t6_after_err", 32'(a_err), 32'd0);
        check("t6_after_grant", 32'(a_grant), 32'd3);
`else
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t6_hold_scyc%0d", k), 32'(a_s_cyc), 32'd1);
            check($sformatf("t6_hold_err%0d", k), 32'({a_err, a_m2_ack}), 32'd0);
            step();
        end
        m2_cyc = 1'b0;
        step();
        check("t6_abort_grant", 32'(a_grant), 32'd3);
`endif

        // reset in the middle of a BUSY transfer
        m2_cyc = 1'b1;
        step();
        check("rmid_busy", 32'(a_s_cyc), 32'd1);
        s_ack = 1'b1; s_rdt = 32'h13572468;
        rst = 1'b1;
        #1;
        check("rmid_scyc", 32'(a_s_cyc), 32'd0);
        check("rmid_grant", 32'(a_grant), 32'd3);
        check("rmid_ack", 32'({a_m0_ack, a_m1_ack, a_m2_ack, a_err}), 32'd0);
        check("rmid_rdt", a_m2_rdt, 32'd0);
        step();
        s_ack = 1'b0; m2_cyc = 1'b0;
        rst = 1'b0;
        step();
        check("rmid_idle", 32'(a_grant), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
